// File: rtl/uart_tb_pkg.sv
// Shared definitions for the bench-side 8N1 UART transceiver.
// Holds the default bit timing and the state encoding used by the TX and RX FSMs.
package uart_tb_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 4167;
  localparam int unsigned HALF_BIT             = CLKS_PER_BIT_DEFAULT / 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_tb_rx.sv
// Receive half of the bench UART: input synchronizer, RX FSM and
// one-cycle valid / framing-error strobes.
module uart_tb_rx
  import uart_tb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [2:0]      LastBit  = 3'(DATA_BITS - 1);

  uart_state_e     r_state_q, r_state_d;
  logic [CntW-1:0] r_cnt_q, r_cnt_d;
  logic [2:0]      r_bit_q, r_bit_d;
  logic [7:0]      r_shift_q, r_shift_d;
  logic [7:0]      r_data_q, r_data_d;
  logic            r_valid_q, r_valid_d;
  logic            r_err_q, r_err_d;
  logic            r_wait_high_q, r_wait_high_d;
  logic [1:0]      r_sync_q;
  logic            r_prev_q;
  logic            w_rx;
  logic            w_fall;

  assign w_rx   = r_sync_q[1];
  assign w_fall = r_prev_q & ~w_rx;

  always_comb begin
    r_state_d     = r_state_q;
    r_cnt_d       = r_cnt_q;
    r_bit_d       = r_bit_q;
    r_shift_d     = r_shift_q;
    r_data_d      = r_data_q;
    r_valid_d     = 1'b0;
    r_err_d       = 1'b0;
    r_wait_high_d = r_wait_high_q;
    case (r_state_q)
      StIdle: begin
        if (w_fall) begin
          r_cnt_d   = '0;
          r_state_d = StStart;
        end
      end
      StStart: begin
        if (r_cnt_q == HalfLast) begin
          r_cnt_d   = '0;
          r_bit_d   = '0;
          // A start bit that is already gone at its centre was a glitch.
          r_state_d = w_rx ? StIdle : StData;
        end else begin
          r_cnt_d = r_cnt_q + CntOne;
        end
      end
      StData: begin
        if (r_cnt_q == LastCnt) begin
          r_cnt_d   = '0;
          r_shift_d = {w_rx, r_shift_q[7:1]};
          if (r_bit_q == LastBit) r_state_d = StStop;
          else                    r_bit_d   = r_bit_q + 3'd1;
        end else begin
          r_cnt_d = r_cnt_q + CntOne;
        end
      end
      StStop: begin
        if (r_wait_high_q) begin
          if (w_rx) begin
            r_wait_high_d = 1'b0;
            r_state_d     = StIdle;
          end
        end else if (r_cnt_q == LastCnt) begin
          r_cnt_d = '0;
          if (w_rx) begin
            r_data_d  = r_shift_q;
            r_valid_d = 1'b1;
            r_state_d = StIdle;
          end else begin
            r_err_d       = 1'b1;
            r_wait_high_d = 1'b1;
          end
        end else begin
          r_cnt_d = r_cnt_q + CntOne;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q     <= StIdle;
      r_cnt_q       <= '0;
      r_bit_q       <= '0;
      r_shift_q     <= '0;
      r_data_q      <= '0;
      r_valid_q     <= 1'b0;
      r_err_q       <= 1'b0;
      r_wait_high_q <= 1'b0;
      r_sync_q      <= 2'b11;
      r_prev_q      <= 1'b1;
    end else begin
      r_state_q     <= r_state_d;
      r_cnt_q       <= r_cnt_d;
      r_bit_q       <= r_bit_d;
      r_shift_q     <= r_shift_d;
      r_data_q      <= r_data_d;
      r_valid_q     <= r_valid_d;
      r_err_q       <= r_err_d;
      r_wait_high_q <= r_wait_high_d;
      r_sync_q      <= {r_sync_q[0], ser_rx};
      r_prev_q      <= w_rx;
    end
  end

  assign rx_data      = r_data_q;
  assign rx_valid     = r_valid_q;
  assign rx_frame_err = r_err_q;

endmodule

// File: rtl/uart_tb_xcvr.sv
// Bench-side 8N1 UART transceiver: edge-triggered TX FSM here, RX in uart_tb_rx.
// TX and RX are independent and may be looped back externally.
module uart_tb_xcvr
  import uart_tb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [2:0]      LastBit = 3'(DATA_BITS - 1);

  uart_state_e     r_tx_state_q, r_tx_state_d;
  logic [CntW-1:0] r_tx_cnt_q, r_tx_cnt_d;
  logic [2:0]      r_tx_bit_q, r_tx_bit_d;
  logic [7:0]      r_tx_shift_q, r_tx_shift_d;
  logic            r_tx_clear_q, r_tx_clear_d;
  logic            r_tx_start_q;
  logic            w_start_evt;

  // Resets low so a request held through reset still launches one frame.
  assign w_start_evt = tx_start & ~r_tx_start_q;

  always_comb begin
    r_tx_state_d = r_tx_state_q;
    r_tx_cnt_d   = r_tx_cnt_q;
    r_tx_bit_d   = r_tx_bit_q;
    r_tx_shift_d = r_tx_shift_q;
    r_tx_clear_d = 1'b0;
    case (r_tx_state_q)
      StIdle: begin
        if (w_start_evt) begin
          r_tx_shift_d = tx_data;
          r_tx_cnt_d   = '0;
          r_tx_state_d = StStart;
        end
      end
      StStart: begin
        if (r_tx_cnt_q == LastCnt) begin
          r_tx_cnt_d   = '0;
          r_tx_bit_d   = '0;
          r_tx_state_d = StData;
        end else begin
          r_tx_cnt_d = r_tx_cnt_q + CntOne;
        end
      end
      StData: begin
        if (r_tx_cnt_q == LastCnt) begin
          r_tx_cnt_d   = '0;
          r_tx_shift_d = {1'b1, r_tx_shift_q[7:1]};
          if (r_tx_bit_q == LastBit) r_tx_state_d = StStop;
          else                       r_tx_bit_d   = r_tx_bit_q + 3'd1;
        end else begin
          r_tx_cnt_d = r_tx_cnt_q + CntOne;
        end
      end
      StStop: begin
        if (r_tx_cnt_q == LastCnt) begin
          r_tx_cnt_d   = '0;
          r_tx_clear_d = 1'b1;
          r_tx_state_d = StIdle;
        end else begin
          r_tx_cnt_d = r_tx_cnt_q + CntOne;
        end
      end
      default: r_tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state_q <= StIdle;
      r_tx_cnt_q   <= '0;
      r_tx_bit_q   <= '0;
      r_tx_shift_q <= '0;
      r_tx_clear_q <= 1'b0;
      r_tx_start_q <= 1'b0;
    end else begin
      r_tx_state_q <= r_tx_state_d;
      r_tx_cnt_q   <= r_tx_cnt_d;
      r_tx_bit_q   <= r_tx_bit_d;
      r_tx_shift_q <= r_tx_shift_d;
      r_tx_clear_q <= r_tx_clear_d;
      r_tx_start_q <= tx_start;
    end
  end

  always_comb begin
    ser_tx = 1'b1;
    case (r_tx_state_q)
      StStart: ser_tx = 1'b0;
      StData:  ser_tx = r_tx_shift_q[0];
      default: ser_tx = 1'b1;
    endcase
  end

  assign tx_busy      = (r_tx_state_q != StIdle);
  assign tx_clear_req = r_tx_clear_q;

  uart_tb_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

endmodule

// File: tb/tb_uart_tb_xcvr.sv
// Directed self-checking bench for uart_tb_xcvr at 16 clocks per bit.
module tb_uart_tb_xcvr;

  localparam int unsigned Cpb = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_rx_drv;
  logic       loopback;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       w_ser_rx;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         cnt_valid      = 0;
  int         cnt_err        = 0;
  int         cnt_clear      = 0;
  int         cnt_busy       = 0;
  int         cnt_busy_rise  = 0;
  int         clear_misalign = 0;
  int         low_run        = 0;
  int         last_low_run   = 0;
  logic       prev_busy      = 1'b0;
  logic [7:0] last_rx        = 8'h00;

  int b_valid, b_err, b_clear, b_busy, b_rise;

  always #5 clock = ~clock;

  assign w_ser_rx = loopback ? ser_tx : ser_rx_drv;

  uart_tb_xcvr #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ser_rx       (w_ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  // Event monitor sampled on the inactive edge.
  always @(negedge clock) begin
    if (rx_valid) begin
      cnt_valid <= cnt_valid + 1;
      last_rx   <= rx_data;
    end
    if (rx_frame_err) cnt_err <= cnt_err + 1;
    if (tx_clear_req) begin
      cnt_clear <= cnt_clear + 1;
      if (!(prev_busy && !tx_busy)) clear_misalign <= clear_misalign + 1;
    end
    if (tx_busy) cnt_busy <= cnt_busy + 1;
    if (tx_busy && !prev_busy) cnt_busy_rise <= cnt_busy_rise + 1;
    prev_busy <= tx_busy;
    if (ser_tx == 1'b0) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) last_low_run <= low_run;
      low_run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (tx_busy !== lvl && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, {31'd0, tx_busy}, {31'd0, lvl});
  endtask

  task automatic snap();
    b_valid = cnt_valid;
    b_err   = cnt_err;
    b_clear = cnt_clear;
    b_busy  = cnt_busy;
    b_rise  = cnt_busy_rise;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    ser_rx_drv = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx_drv = b[i];
      repeat (Cpb) @(negedge clock);
    end
    ser_rx_drv = stop_bit;
    repeat (Cpb) @(negedge clock);
    ser_rx_drv = 1'b1;
    repeat (Cpb) @(negedge clock);
  endtask

  initial begin
    logic [7:0] obs_bits;
    reset      = 1'b1;
    ser_rx_drv = 1'b1;
    loopback   = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_eq("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
    check_eq("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_clear_req", {31'd0, tx_clear_req}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_rx_err", {31'd0, rx_frame_err}, 32'd0);

    // TX 0x00: start + 8 zero bits give one 144-cycle low run.
    snap();
    tx_data  = 8'h00;
    tx_start = 1'b1;
    wait_busy(1'b1, "t00_busy_rise");
    wait_busy(1'b0, "t00_busy_fall");
    repeat (3) @(negedge clock);
    check_eq("t00_busy_cycles", cnt_busy - b_busy, 32'd160);
    check_eq("t00_clear_pulses", cnt_clear - b_clear, 32'd1);
    check_eq("t00_low_run", last_low_run, 32'd144);
    check_eq("t00_ser_tx_idle", {31'd0, ser_tx}, 32'd1);
    tx_start = 1'b0;
    repeat (5) @(negedge clock);

    // Loopback 0xA5 with bit-centre sampling of ser_tx.
    loopback = 1'b1;
    snap();
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    wait_busy(1'b1, "a5_busy_rise");
    obs_bits = 8'h00;
    repeat (Cpb + Cpb / 2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      obs_bits[i] = ser_tx;
      if (i < 7) repeat (Cpb) @(negedge clock);
    end
    check_eq("a5_bit_order", {24'd0, obs_bits}, 32'b1010_0101);
    wait_busy(1'b0, "a5_busy_fall");
    repeat (5) @(negedge clock);
    check_eq("a5_rx_valid_cnt", cnt_valid - b_valid, 32'd1);
    check_eq("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    check_eq("a5_rx_err_cnt", cnt_err - b_err, 32'd0);
    tx_start = 1'b0;
    repeat (5) @(negedge clock);

    // Level held high sends once; edge during busy is dropped.
    snap();
    tx_data  = 8'h11;
    tx_start = 1'b1;
    repeat (500) @(negedge clock);
    check_eq("hold_frames", cnt_busy_rise - b_rise, 32'd1);
    check_eq("hold_rx_cnt", cnt_valid - b_valid, 32'd1);
    check_eq("hold_rx_byte", {24'd0, last_rx}, 32'h11);
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = 8'h22;
    tx_start = 1'b1;
    repeat (30) @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'h33;
    @(negedge clock);
    tx_start = 1'b1;
    wait_busy(1'b0, "edge_busy_fall");
    repeat (200) @(negedge clock);
    check_eq("edge_frames", cnt_busy_rise - b_rise, 32'd2);
    check_eq("edge_rx_cnt", cnt_valid - b_valid, 32'd2);
    check_eq("edge_rx_byte", {24'd0, last_rx}, 32'h22);
    tx_start = 1'b0;
    loopback = 1'b0;
    repeat (5) @(negedge clock);

    // Framing error keeps rx_data; a good frame afterwards is accepted.
    snap();
    send_rx(8'h3C, 1'b0);
    repeat (20) @(negedge clock);
    check_eq("ferr_err_cnt", cnt_err - b_err, 32'd1);
    check_eq("ferr_valid_cnt", cnt_valid - b_valid, 32'd0);
    check_eq("ferr_rx_data", {24'd0, rx_data}, 32'h22);
    send_rx(8'h96, 1'b1);
    repeat (20) @(negedge clock);
    check_eq("ferr_next_valid", cnt_valid - b_valid, 32'd1);
    check_eq("ferr_next_data", {24'd0, rx_data}, 32'h96);

    // Four-cycle glitch is rejected, then a real frame still lands.
    snap();
    ser_rx_drv = 1'b0;
    repeat (4) @(negedge clock);
    ser_rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    check_eq("glitch_valid_cnt", cnt_valid - b_valid, 32'd0);
    check_eq("glitch_err_cnt", cnt_err - b_err, 32'd0);
    send_rx(8'h69, 1'b1);
    repeat (20) @(negedge clock);
    check_eq("glitch_next_valid", cnt_valid - b_valid, 32'd1);
    check_eq("glitch_next_data", {24'd0, rx_data}, 32'h69);

    // Reset 50 cycles into a frame, then a clean 0x5A frame.
    snap();
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    wait_busy(1'b1, "rst_busy_rise");
    repeat (50) @(negedge clock);
    reset    = 1'b1;
    tx_start = 1'b0;
    @(negedge clock);
    check_eq("rstmid_ser_tx", {31'd0, ser_tx}, 32'd1);
    check_eq("rstmid_tx_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("rstmid_no_clear", cnt_clear - b_clear, 32'd0);
    check_eq("rstmid_rx_data", {24'd0, rx_data}, 32'h00);
    loopback = 1'b1;
    snap();
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    wait_busy(1'b1, "5a_busy_rise");
    wait_busy(1'b0, "5a_busy_fall");
    repeat (5) @(negedge clock);
    check_eq("5a_busy_cycles", cnt_busy - b_busy, 32'd160);
    check_eq("5a_clear_pulses", cnt_clear - b_clear, 32'd1);
    check_eq("5a_rx_valid_cnt", cnt_valid - b_valid, 32'd1);
    check_eq("5a_rx_data", {24'd0, rx_data}, 32'h5A);
    tx_start = 1'b0;

    check_eq("clear_alignment", clear_misalign, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tb_xcvr.md
Name: uart_tb_xcvr

Overview:
Synthesizable 8N1 UART transceiver that stands in for the bench-side UART attached to the SoC's user I/O pins (SoC TX pad drives ser_rx, ser_tx drives SoC RX pad).
- TX side sends one byte per tx_start request and reports completion through tx_busy and tx_clear_req.
- RX side deserializes bytes from the SoC and presents them with a one-cycle valid strobe and a framing-error strobe.

Parameters:
CLKS_PER_BIT, 4167, clock cycles per UART bit (40 MHz / 9600 baud); must be >= 4
DATA_BITS, 8, payload bits per frame; fixed at 8, parameterised for documentation only

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ser_rx  input  1  serial line from SoC TX, asynchronous, idle high
ser_tx  output  1  serial line to SoC RX, idle high
tx_start  input  1  transmit request, level signal; a rising edge launches one frame
tx_data  input  8  byte to send, sampled on the cycle the rising edge of tx_start is detected
tx_busy  output  1  high while a TX frame is in flight
tx_clear_req  output  1  one-cycle pulse at frame completion, asking the requester to drop tx_start
rx_data  output  8  last received byte, held until the next valid frame
rx_valid  output  1  one-cycle strobe, rx_data updated with a good frame
rx_frame_err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset values: ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0x00, rx_valid=0, rx_frame_err=0. All FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame. ser_tx is high on the first cycle after reset is sampled, and no strobes are issued for the aborted frame.
- TX rising-edge detect:
  - Register tx_start_q; start_evt = tx_start & ~tx_start_q. tx_start_q resets to 0, so tx_start held high through reset counts as an edge once reset drops.
  - A level held high after completion never re-sends.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE + start_evt: latch tx_data into the shift register; go to START on the next cycle, with ser_tx=0 and tx_busy=1.
  - START holds for CLKS_PER_BIT cycles.
  - DATA sends 8 bits LSB first, each held CLKS_PER_BIT cycles.
  - STOP holds ser_tx=1 for CLKS_PER_BIT cycles.
  - On leaving STOP: tx_busy=0 and tx_clear_req=1 for exactly one cycle, then back to IDLE.
  - Total tx_busy high time is exactly 10*CLKS_PER_BIT cycles.
- start_evt while tx_busy=1 is ignored and not queued. tx_data changes during a frame have no effect.
- RX path:
  - ser_rx passes through a 2-flop synchronizer (both flops reset to 1), then a falling-edge detect in IDLE enters START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then resample. If the line is high, treat it as a glitch and return to IDLE with no strobe; if low, go to DATA.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals from the start-bit centre, shifting LSB first.
  - STOP: sample once more after CLKS_PER_BIT.
    - High: rx_data <= shifted byte and rx_valid=1 for one cycle.
    - Low: rx_frame_err=1 for one cycle and rx_data is unchanged. Then wait for the line to go high before re-arming IDLE.
- RX and TX are fully independent and can run simultaneously, including internal loopback (ser_tx tied to ser_rx).
- Counters are sized to $clog2(CLKS_PER_BIT) bits and wrap only by explicit clear.

Decomposition:
- Package uart_tb_pkg holds:
  - CLKS_PER_BIT default and the derived HALF_BIT constant
  - an enum shared by both FSMs: IDLE, START, DATA, STOP
- Natural sub-module: uart_tb_rx, covering the synchronizer, RX FSM and strobes.
- TX FSM and the edge detect stay in the top module.

Test Plan (CLKS_PER_BIT=16):
- TX byte 0x00: tx_start 0->1 with tx_data=0x00 -> ser_tx low for 144 consecutive cycles then high. tx_busy high for 160 cycles. tx_clear_req a single pulse as tx_busy falls.
- Loopback 0xA5 (ser_tx tied to ser_rx): rx_valid pulses once with rx_data=0xA5, no rx_frame_err. Observed bit order on ser_tx after the start bit: 1,0,1,0,0,1,0,1.
- tx_start held high 500 cycles: exactly one frame is sent, a second rising edge during busy is ignored, and the next edge after tx_busy=0 sends a new frame.
- Frame error: drive ser_rx with 0x3C framed with a low stop bit -> rx_frame_err pulses once, rx_valid stays 0, rx_data keeps its prior value.
- Glitch rejection: ser_rx low for 4 cycles then high -> no rx_valid or rx_frame_err, and the RX FSM returns to IDLE.
- Reset at cycle 50 of a TX frame: ser_tx=1 and tx_busy=0 on the next cycle, no tx_clear_req pulse, and a subsequent frame of 0x5A is sent correctly.
